// File: rtl/queue_if.sv
// queue_if: request, data and status bundle between a queue user and queue_ctrl
interface queue_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic             enq, deq, clr_err;
  logic [WIDTH-1:0] din, dout, dbg_data;
  logic [AW-1:0]    dbg_addr, rp, wp;
  logic             full, empty, almost_full, ovf, udf;
  logic [AW:0]      count;
  logic [DEPTH-1:0] valid;
  modport master (
    output enq, deq, din, clr_err, dbg_addr,
    input  dout, dbg_data, full, empty, almost_full, count, valid, rp, wp, ovf, udf
  );
  modport slave (
    input  enq, deq, din, clr_err, dbg_addr,
    output dout, dbg_data, full, empty, almost_full, count, valid, rp, wp, ovf, udf
  );
endinterface

// File: rtl/queue_ctrl.sv
// queue_ctrl: circular queue with optional button edge detection, status flags and sticky errors
module queue_ctrl #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AW       = $clog2(DEPTH),
  parameter int EDGE_DET = 1,
  parameter int AF_LVL   = DEPTH - 1
) (
  input logic   clk,
  input logic   rst,
  queue_if.slave q
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             e1_q, e2_q, d1_q, d2_q;
  logic             pe, pd, full, empty, do_enq, do_deq;
  always_comb begin
    pe      = EDGE_DET != 0 ? e1_q & ~e2_q : q.enq;
    pd      = EDGE_DET != 0 ? d1_q & ~d2_q : q.deq;
    full    = count_q == FULL_CNT;
    empty   = count_q == '0;
    do_enq  = pe & (~full | pd);
    do_deq  = pd & ~empty;
    mem_d   = mem_q;
    valid_d = valid_q;
    // clear before set: on a full queue wp == rp and the new entry reoccupies the vacated slot
    if (do_deq) valid_d[rp_q] = 1'b0;
    if (do_enq) begin
      mem_d[wp_q]   = q.din;
      valid_d[wp_q] = 1'b1;
    end
    rp_d    = do_deq ? rp_q + 1'b1 : rp_q;
    wp_d    = do_enq ? wp_q + 1'b1 : wp_q;
    count_d = count_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
    ovf_d   = (pe & full & ~pd) | (ovf_q & ~q.clr_err);
    udf_d   = (pd & empty) | (udf_q & ~q.clr_err);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      valid_q <= '0;
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      // a button held through reset must be released before it can commit
      {e1_q, e2_q, d1_q, d2_q} <= '1;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      e1_q    <= q.enq;
      e2_q    <= e1_q;
      d1_q    <= q.deq;
      d2_q    <= d1_q;
    end
  end
  assign q.dout        = empty ? '0 : mem_q[rp_q];
  assign q.dbg_data    = mem_q[q.dbg_addr];
  assign q.full        = full;
  assign q.empty       = empty;
  assign q.almost_full = count_q >= AF_CNT;
  assign q.count       = count_q;
  assign q.valid       = valid_q;
  assign q.rp          = rp_q;
  assign q.wp          = wp_q;
  assign q.ovf         = ovf_q;
  assign q.udf         = udf_q;
endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl: directed and random checks of two queue_ctrl configurations against a queue-based model
module tb_queue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  always #5 clk = ~clk;
  queue_if #(.WIDTH(4), .DEPTH(8)) ia ();
  queue_if #(.WIDTH(8), .DEPTH(4)) ib ();
  queue_ctrl #(.WIDTH(4), .DEPTH(8)) ua (.clk(clk), .rst(rst), .q(ia));
  queue_ctrl #(.WIDTH(8), .DEPTH(4), .EDGE_DET(0), .AF_LVL(3)) ub (.clk(clk), .rst(rst), .q(ib));
  int qa[$];
  int qb[$];
  int dep[2] = '{8, 4};
  int afl[2] = '{7, 3};
  int rp_m[2], wp_m[2];
  bit ovf_m[2], udf_m[2];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  task automatic reset_model();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      rp_m[i] = 0; wp_m[i] = 0; ovf_m[i] = 0; udf_m[i] = 0;
    end
  endtask
  task automatic step_model(input int i, input bit pe, input bit pd, input int v);
    int  n  = i == 0 ? qa.size() : qb.size();
    bit  fl = n == dep[i];
    bit  em = n == 0;
    bit  de = pe && (!fl || pd);
    bit  dd = pd && !em;
    if (pe && fl && !pd) ovf_m[i] = 1;
    if (pd && em) udf_m[i] = 1;
    if (dd) begin
      if (i == 0) void'(qa.pop_front()); else void'(qb.pop_front());
      rp_m[i] = (rp_m[i] + 1) % dep[i];
    end
    if (de) begin
      if (i == 0) qa.push_back(v); else qb.push_back(v);
      wp_m[i] = (wp_m[i] + 1) % dep[i];
    end
  endtask
  function automatic int vmask(input int i, input int n);
    int m = 0;
    for (int k = 0; k < n; k++) m |= 1 << ((rp_m[i] + k) % dep[i]);
    return m;
  endfunction
  task automatic chk_all(input int i, input string t);
    int n = i == 0 ? qa.size() : qb.size();
    int h = n == 0 ? 0 : (i == 0 ? qa[0] : qb[0]);
    if (i == 0) begin
      chk({t, ".count"}, ia.count, n);
      chk({t, ".full"}, ia.full, n == dep[0]);
      chk({t, ".empty"}, ia.empty, n == 0);
      chk({t, ".af"}, ia.almost_full, n >= afl[0]);
      chk({t, ".valid"}, ia.valid, vmask(0, n));
      chk({t, ".dout"}, ia.dout, h);
      chk({t, ".rp"}, ia.rp, rp_m[0]);
      chk({t, ".wp"}, ia.wp, wp_m[0]);
      chk({t, ".ovf"}, ia.ovf, ovf_m[0]);
      chk({t, ".udf"}, ia.udf, udf_m[0]);
    end else begin
      chk({t, ".count"}, ib.count, n);
      chk({t, ".full"}, ib.full, n == dep[1]);
      chk({t, ".empty"}, ib.empty, n == 0);
      chk({t, ".af"}, ib.almost_full, n >= afl[1]);
      chk({t, ".valid"}, ib.valid, vmask(1, n));
      chk({t, ".dout"}, ib.dout, h);
      chk({t, ".ovf"}, ib.ovf, ovf_m[1]);
      chk({t, ".udf"}, ib.udf, udf_m[1]);
    end
  endtask
  task automatic press(input bit e, input bit d, input int v);
    ia.enq = e; ia.deq = d; ia.din = 4'(v);
    tick();
    tick();
    ia.enq = 0; ia.deq = 0;
    tick();
    tick();
    step_model(0, e, d, v);
  endtask
  initial begin
    ia.enq = 0; ia.deq = 0; ia.din = 0; ia.clr_err = 0; ia.dbg_addr = 0;
    ib.enq = 0; ib.deq = 0; ib.din = 0; ib.clr_err = 0; ib.dbg_addr = 0;
    tick();
    tick();
    rst = 0;
    reset_model();
    tick();
    tick();
    chk_all(0, "rst_a");
    chk_all(1, "rst_b");
    for (int k = 0; k < 8; k++) begin
      ia.dbg_addr = 3'(k);
      #1 chk("rst_mem", ia.dbg_data, 0);
    end
    for (int k = 1; k <= 8; k++) begin
      press(1, 0, k);
      chk_all(0, "fill");
    end
    chk("fill_full", ia.full, 1);
    chk("fill_valid", ia.valid, 8'hFF);
    press(1, 0, 9);
    chk_all(0, "ovf");
    chk("ovf_flag", ia.ovf, 1);
    for (int k = 0; k < 8; k++) begin
      ia.dbg_addr = 3'(k);
      #1 chk("ovf_mem", ia.dbg_data, k + 1);
    end
    ia.clr_err = 1;
    tick();
    ia.clr_err = 0;
    ovf_m[0] = 0;
    chk_all(0, "clr_ovf");
    press(1, 1, 9);
    chk_all(0, "full_both");
    chk("both_dout", ia.dout, 2);
    ia.dbg_addr = 0;
    #1 chk("both_mem0", ia.dbg_data, 9);
    for (int k = 0; k < 8; k++) begin
      press(0, 1, 0);
      chk_all(0, "drain");
    end
    chk("drain_empty", ia.empty, 1);
    press(0, 1, 0);
    chk_all(0, "udf");
    chk("udf_rp", ia.rp, 1);
    ia.clr_err = 1;
    tick();
    ia.clr_err = 0;
    udf_m[0] = 0;
    chk_all(0, "clr_udf");
    ia.deq = 1;
    tick();
    ia.clr_err = 1;
    tick();
    ia.clr_err = 0; ia.deq = 0;
    tick();
    tick();
    udf_m[0] = 1;
    chk_all(0, "clr_vs_err");
    ia.enq = 1; ia.din = 5;
    tick();
    chk("hold_k", ia.count, 0);
    tick();
    step_model(0, 1, 0, 5);
    chk_all(0, "hold_k1");
    for (int k = 0; k < 18; k++) tick();
    chk_all(0, "hold_20");
    ia.enq = 0;
    tick();
    tick();
    chk_all(0, "hold_rel");
    ia.enq = 1; ia.din = 7; rst = 1;
    tick();
    tick();
    rst = 0;
    reset_model();
    for (int k = 0; k < 5; k++) tick();
    chk_all(0, "rst_held");
    ia.enq = 0;
    tick();
    tick();
    chk_all(0, "rst_rel");
    press(1, 0, 3);
    chk_all(0, "post_rst");
    for (int k = 0; k < 3; k++) begin
      ib.enq = 1; ib.din = 8'(8'h10 + k);
      tick();
      ib.enq = 0;
      step_model(1, 1, 0, 8'h10 + k);
      chk_all(1, "strobe");
    end
    chk("strobe_af", ib.almost_full, 1);
    for (int k = 0; k < 20; k++) begin
      ib.enq = 1'($urandom);
      ib.deq = 1'($urandom);
      ib.din = 8'($urandom);
      tick();
      step_model(1, ib.enq, ib.deq, int'(ib.din));
      chk_all(1, "rand");
    end
    ib.enq = 0; ib.deq = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/queue_ctrl.md
QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, data width in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two, 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH), pointer width.
REQ-004 Parameter EDGE_DET, default 1; 1 = enq/deq are level inputs (buttons), internally edge-detected; 0 = enq/deq are single-cycle strobes used directly.
REQ-005 Parameter AF_LVL, default DEPTH-1, almost-full threshold in entries.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enq  in  1  enqueue request.
REQ-009 deq  in  1  dequeue request.
REQ-010 din  in  WIDTH  enqueue data.
REQ-011 clr_err  in  1  clears the sticky error flags.
REQ-012 dbg_addr  in  AW  display/scan read address.
REQ-013 dout  out  WIDTH  head entry, mem[rp]; 0 when empty.
REQ-014 dbg_data  out  WIDTH  mem[dbg_addr], combinational, for segment scanning.
REQ-015 full / empty / almost_full  out  1 each  status flags.
REQ-016 count  out  AW+1  occupancy, 0..DEPTH.
REQ-017 valid  out  DEPTH  per-slot occupancy bitmap.
REQ-018 rp / wp  out  AW  read/write pointers.
REQ-019 ovf / udf  out  1 each  sticky overflow/underflow flags.

Function
REQ-020 EDGE_DET=1: enq sampled into e1, then e2; pe = e1 & ~e2; same for deq (pd). EDGE_DET=0: pe = enq, pd = deq.
REQ-021 With EDGE_DET=1, a rising enq seen at edge k commits at edge k+1; one commit per press regardless of hold time.
REQ-022 Enqueue accepted when pe & (!full | pd): mem[wp] <= din, valid[wp] <= 1, wp <= wp+1 (mod DEPTH).
REQ-023 Dequeue accepted when pd & !empty: valid[rp] <= 0, rp <= rp+1 (mod DEPTH).
REQ-024 pe & full & !pd: write rejected, storage/pointers unchanged, ovf <= 1.
REQ-025 pd & empty: dequeue rejected, udf <= 1; a simultaneous pe still enqueues.
REQ-026 pe & pd & full: both performed in the same edge; count stays DEPTH, full stays 1; the new data goes to the slot just vacated.
REQ-027 pe & pd & neither full nor empty: both performed; count unchanged.
REQ-028 count is a register: +1 on enqueue only, -1 on dequeue only, else held.
REQ-029 full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_LVL); all derived from the count register, so they are valid in the cycle after the commit edge.
REQ-030 Pointers wrap from DEPTH-1 to 0 with no special cases; valid always has exactly count bits set.
REQ-031 dout follows rp combinationally; after a dequeue it shows the next entry in the following cycle; when empty, dout = 0.
REQ-032 clr_err clears ovf/udf at the next edge; a new error in the same cycle wins (flag set).

Reset
REQ-033 rst at any edge: rp=wp=0, count=0, valid=0, empty=1, full=0, almost_full=0, ovf=udf=0, all mem entries 0; overrides any pe/pd in that cycle.
REQ-034 rst loads e1=e2=1 (and d1=d2=1), so a button held through reset does not cause a commit until it is released and pressed again.
REQ-035 rst asserted mid-operation discards any pending pulse; behaviour afterwards is identical to power-up.

Verification
REQ-036 Reset, then 8 single-press enqueues of 1..8 (DEPTH=8) -> full=1, count=8, valid=8'hFF, dout=1, wp=0.
REQ-037 Full, one more press with din=9 -> ovf=1, contents unchanged; clr_err -> ovf=0.
REQ-038 Full, enq and deq pressed on the same cycle with din=9 -> dout changes 1->2, count=8, mem[0]=9, rp=wp=1.
REQ-039 Drain with 8 deq presses -> dout sequence 2..8,9, then empty=1, dout=0; a ninth deq -> udf=1, rp unchanged.
REQ-040 enq held high for 20 cycles -> exactly one enqueue, committed two edges after the rise; enq held high across rst -> no enqueue after reset.
REQ-041 EDGE_DET=0, DEPTH=4, WIDTH=8: strobes push 3 entries -> almost_full=1 with AF_LVL=3; 20 random mixed cycles -> count, valid and dout match a scoreboard model.
